// File: rtl/dmrs_pkg.sv
// Shared types and constants for the PUSCH DM-RS phase generator.
// Phases are unsigned turns of 2*pi, modulo 1.
package dmrs_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StRun,
        StDone
    } state_e;

    // Lengths at or above this use the Zadoff-Chu recursion; below it the phi table.
    localparam int unsigned SHORT_LEN_MAX = 36;
    // Length-30 sequences reuse the ZC path with Nzc=31 and a +1 index offset.
    localparam int unsigned M30_LEN       = 30;

    localparam int unsigned DEF_PHASE_W   = 15;
    localparam int unsigned DEF_STEP_W    = 26;
    localparam int unsigned DEF_LEN_W     = 10;
    // Fractional width of the 1/nzc reciprocal input.
    localparam int unsigned REC_FRAC_W    = 30;

    // phi*pi/4 as a Q0.32 turn value: phi/8 turns, i.e. phi in the top three bits.
    function automatic logic [31:0] phi_to_turns(input logic [2:0] phi);
        return {phi, 29'd0};
    endfunction

endpackage

// File: rtl/zc_phase_accum.sv
// Zadoff-Chu phase recursion: tracks m = (n + offset) mod nzc together with the
// running step (m*q/nzc) and the phase zc(m) = -sum(step) turns.
module zc_phase_accum
    import dmrs_pkg::*;
#(
    parameter int unsigned PHASE_W = DEF_PHASE_W,
    parameter int unsigned STEP_W  = DEF_STEP_W,
    parameter int unsigned LEN_W   = DEF_LEN_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               init_i,
    input  logic               offset_i,
    input  logic               advance_i,
    input  logic [STEP_W-1:0]  step_inc_i,
    input  logic [LEN_W-1:0]   nzc_i,
    output logic [PHASE_W-1:0] zc_o
);

    localparam int unsigned RND_SH = STEP_W - PHASE_W;

    logic [LEN_W-1:0]   m_q, m_d;
    logic [STEP_W-1:0]  step_q, step_d, base_step, adv_step;
    logic [PHASE_W-1:0] zc_q, zc_d, base_zc, adv_zc;
    logic [STEP_W:0]    step_rnd;

    // One recursion step from either the cleared state (init) or the current state.
    always_comb begin
        base_step = init_i ? '0 : step_q;
        base_zc   = init_i ? '0 : zc_q;
        adv_step  = base_step + step_inc_i;
        step_rnd  = {1'b0, adv_step} + ((STEP_W + 1)'(1) << (RND_SH - 1));
        adv_zc    = base_zc - PHASE_W'(step_rnd >> RND_SH);

        m_d    = m_q;
        step_d = step_q;
        zc_d   = zc_q;
        if (init_i) begin
            if (offset_i) begin
                m_d    = LEN_W'(1);
                step_d = adv_step;
                zc_d   = adv_zc;
            end else begin
                m_d    = '0;
                step_d = '0;
                zc_d   = '0;
            end
        end else if (advance_i) begin
            // Cyclic extension: after m = nzc-1 the sequence restarts at m = 0.
            if (m_q == nzc_i - LEN_W'(1)) begin
                m_d    = '0;
                step_d = '0;
                zc_d   = '0;
            end else begin
                m_d    = m_q + LEN_W'(1);
                step_d = adv_step;
                zc_d   = adv_zc;
            end
        end
    end

    // Recursion state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_q    <= '0;
            step_q <= '0;
            zc_q   <= '0;
        end else begin
            m_q    <= m_d;
            step_q <= step_d;
            zc_q   <= zc_d;
        end
    end

    assign zc_o = zc_q;

endmodule

// File: rtl/dmrs_zc_phase_gen.sv
// Multi-port PUSCH DM-RS phase generator: per start, streams m_len phase words per
// antenna port over ready/valid. Optional feature macro: DMRS_CS_EN adds per-port
// cyclic-shift ramps; without it every port carries the bare sequence phase.
module dmrs_zc_phase_gen
    import dmrs_pkg::*;
#(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned PHASE_W = DEF_PHASE_W,
    parameter int unsigned STEP_W  = DEF_STEP_W,
    parameter int unsigned LEN_W   = DEF_LEN_W
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [LEN_W-1:0]           m_len_i,
    input  logic [LEN_W-1:0]           q_i,
    input  logic [LEN_W-1:0]           nzc_i,
    input  logic [REC_FRAC_W-1:0]      nzc_rec_i,
    input  logic [2:0]                 phi_in_i,
    input  logic [N_PORTS*PHASE_W-1:0] cs_step_i,
    output logic [LEN_W-1:0]           idx_o,
    output logic [N_PORTS*PHASE_W-1:0] out_phase_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int unsigned PROD_W = LEN_W + REC_FRAC_W;
    localparam int unsigned INC_SH = REC_FRAC_W - STEP_W;

    state_e             state_q, state_d;
    logic               is_calc, accept, last, offset_d, long_mode, short_mode;
    logic [LEN_W-1:0]   m_len_q, nzc_q, idx_q;
    logic [STEP_W-1:0]  step_inc_q, step_inc_d, step_inc_use;
    logic [PHASE_W-1:0] zc_long, zc_sel;

    assign is_calc  = (state_q == StCalc);
    // abort takes priority over a same-cycle handshake.
    assign accept   = out_valid_o & out_ready_i & ~abort_i;
    assign last     = (idx_q == m_len_q - LEN_W'(1));
    assign offset_d = (m_len_i == LEN_W'(M30_LEN));
    assign idx_o    = idx_q;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StCalc;
            StCalc:  state_d = StRun;
            StRun:   if (accept && last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort_i) state_d = StIdle;
    end

    // FSM outputs.
    always_comb begin
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        unique case (state_q)
            StCalc: busy_o = 1'b1;
            StRun: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
            end
            StDone:  done_o = 1'b1;
            default: ;
        endcase
    end

    // q/nzc step rounded half-up to STEP_W fractional bits; integer turns drop out.
    always_comb begin
        step_inc_d   = STEP_W'((PROD_W'(q_i) * PROD_W'(nzc_rec_i)
                               + (PROD_W'(1) << (INC_SH - 1))) >> INC_SH);
        step_inc_use = is_calc ? step_inc_d : step_inc_q;
    end

    // Sequence parameters latched in CALC; sample index advances per accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_len_q    <= '0;
            nzc_q      <= '0;
            step_inc_q <= '0;
            idx_q      <= '0;
        end else if (is_calc) begin
            m_len_q    <= m_len_i;
            nzc_q      <= nzc_i;
            step_inc_q <= step_inc_d;
            idx_q      <= '0;
        end else if (accept) begin
            idx_q      <= idx_q + LEN_W'(1);
        end
    end

    zc_phase_accum #(
        .PHASE_W (PHASE_W),
        .STEP_W  (STEP_W),
        .LEN_W   (LEN_W)
    ) u_zc_phase_accum (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .init_i     (is_calc),
        .offset_i   (offset_d),
        .advance_i  (accept),
        .step_inc_i (step_inc_use),
        .nzc_i      (nzc_q),
        .zc_o       (zc_long)
    );

    // Sequence phase: ZC recursion, phi table, or zero for unsupported short lengths.
    always_comb begin
        long_mode  = (m_len_q >= LEN_W'(SHORT_LEN_MAX)) || (m_len_q == LEN_W'(M30_LEN));
        short_mode = (m_len_q == LEN_W'(6))  || (m_len_q == LEN_W'(12)) ||
                     (m_len_q == LEN_W'(18)) || (m_len_q == LEN_W'(24));
        if (long_mode) begin
            zc_sel = zc_long;
        end else if (short_mode) begin
            zc_sel = PHASE_W'(phi_to_turns(phi_in_i) >> (32 - PHASE_W));
        end else begin
            zc_sel = '0;
        end
    end

`ifdef DMRS_CS_EN
    logic [N_PORTS-1:0][PHASE_W-1:0] ramp_q, cs_step_q;

    // Per-port cyclic-shift ramps: cleared in CALC, stepped on each accepted sample.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ramp_q    <= '0;
            cs_step_q <= '0;
        end else if (is_calc) begin
            ramp_q    <= '0;
            cs_step_q <= cs_step_i;
        end else if (accept) begin
            for (int k = 0; k < N_PORTS; k++) begin
                ramp_q[k] <= ramp_q[k] + cs_step_q[k];
            end
        end
    end

    // Port phase = sequence phase + port ramp, modulo one turn.
    always_comb begin
        out_phase_o = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            out_phase_o[k*PHASE_W +: PHASE_W] = zc_sel + ramp_q[k];
        end
    end
`else
    logic unused_cs_step;
    assign unused_cs_step = ^cs_step_i;

    // Every port carries the bare sequence phase.
    always_comb begin
        out_phase_o = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            out_phase_o[k*PHASE_W +: PHASE_W] = zc_sel;
        end
    end
`endif

endmodule

// File: tb/tb_dmrs_zc_phase_gen.sv
// Self-checking bench for dmrs_zc_phase_gen: scoreboard of expected samples built
// from an independent sum-form model, popped on each accepted output.
module tb_dmrs_zc_phase_gen;

    localparam int unsigned N_PORTS = 2;
    localparam int unsigned PHASE_W = 15;
    localparam int unsigned STEP_W  = 26;
    localparam int unsigned LEN_W   = 10;
    localparam int unsigned OUT_W   = N_PORTS * PHASE_W;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b0;
    logic               start_i = 1'b0;
    logic               abort_i = 1'b0;
    logic               out_ready_i = 1'b1;
    logic [LEN_W-1:0]   m_len_i = '0;
    logic [LEN_W-1:0]   q_i = '0;
    logic [LEN_W-1:0]   nzc_i = '0;
    logic [29:0]        nzc_rec_i = '0;
    logic [2:0]         phi_in_i = '0;
    logic [OUT_W-1:0]   cs_step_i = '0;
    logic [LEN_W-1:0]   idx_o;
    logic [OUT_W-1:0]   out_phase_o;
    logic               out_valid_o;
    logic               busy_o;
    logic               done_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int               idx;
        logic [OUT_W-1:0] ph;
    } exp_t;
    exp_t sb[$];
    logic [OUT_W-1:0] obs_ph [0:63];

    always #5 clk_i = ~clk_i;

    dmrs_zc_phase_gen #(
        .N_PORTS (N_PORTS),
        .PHASE_W (PHASE_W),
        .STEP_W  (STEP_W),
        .LEN_W   (LEN_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .m_len_i     (m_len_i),
        .q_i         (q_i),
        .nzc_i       (nzc_i),
        .nzc_rec_i   (nzc_rec_i),
        .phi_in_i    (phi_in_i),
        .cs_step_i   (cs_step_i),
        .idx_o       (idx_o),
        .out_phase_o (out_phase_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint rec_of(input int nz);
        return ((longint'(1) << 30) + longint'(nz / 2)) / longint'(nz);
    endfunction

    // zc(n) in closed sum form: -sum_{j=1..m} round(j*q/nzc) turns, m = (n+off) mod nzc.
    function automatic longint exp_zc(input int mlen, input int qv, input int nz,
                                      input int n, input logic [2:0] phi);
        longint inc, acc, m, s;
        acc = 0;
        if (mlen >= 36 || mlen == 30) begin
            inc = ((longint'(qv) * rec_of(nz) + 8) >> 4) & ((longint'(1) << STEP_W) - 1);
            m   = longint'((n + ((mlen == 30) ? 1 : 0)) % nz);
            for (longint j = 1; j <= m; j++) begin
                s   = (j * inc) & ((longint'(1) << STEP_W) - 1);
                acc = acc - ((s + 1024) >> 11);
            end
        end else if (mlen == 6 || mlen == 12 || mlen == 18 || mlen == 24) begin
            acc = longint'($signed(phi)) * 4096;
        end
        return acc & 64'h7fff;
    endfunction

    function automatic logic [OUT_W-1:0] exp_word(input longint zc, input int n,
                                                  input logic [OUT_W-1:0] cs);
        logic [OUT_W-1:0] w;
        w = '0;
        for (int k = 0; k < N_PORTS; k++) begin
`ifdef DMRS_CS_EN
            w[k*PHASE_W +: PHASE_W] = PHASE_W'(zc + longint'(n)
                                      * longint'(cs[k*PHASE_W +: PHASE_W]));
`else
            w[k*PHASE_W +: PHASE_W] = PHASE_W'(zc) | (PHASE_W'(cs) & '0);
`endif
        end
        return w;
    endfunction

    task automatic run_seq(input string tag, input int mlen, input int qv, input int nz,
                           input logic [2:0] phi, input logic [OUT_W-1:0] cs,
                           input int stall_idx, input int start_idx, input int abort_idx);
        int   accepts = 0;
        int   dones = 0;
        int   stall = 0;
        int   tail = -1;
        int   since_abort = -1;
        bit   stalled = 0;
        bit   started = 0;
        bit   aborted = 0;
        exp_t e;
        m_len_i   = LEN_W'(mlen);
        q_i       = LEN_W'(qv);
        nzc_i     = LEN_W'(nz);
        nzc_rec_i = 30'(rec_of(nz));
        phi_in_i  = phi;
        cs_step_i = cs;
        sb.delete();
        for (int n = 0; n < mlen; n++) begin
            sb.push_back('{n, exp_word(exp_zc(mlen, qv, nz, n, phi), n, cs)});
        end
        @(posedge clk_i); #1 start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
        @(negedge clk_i);
        check({tag, " calc busy"}, 64'(busy_o), 1);
        check({tag, " calc valid"}, 64'(out_valid_o), 0);
        for (int cyc = 0; cyc < 400 && tail != 0; cyc++) begin
            @(negedge clk_i);
            if (cyc == 0) check({tag, " first valid"}, 64'(out_valid_o), 1);
            if (since_abort >= 0) since_abort++;
            if (since_abort == 2) begin
                check({tag, " abort valid"}, 64'(out_valid_o), 0);
                check({tag, " abort busy"}, 64'(busy_o), 0);
            end
            if (done_o) dones++;
            if (out_valid_o && !abort_i) begin
                if (sb.size() == 0) begin
                    check({tag, " overrun"}, 64'(idx_o), 64'hffff);
                end else if (out_ready_i) begin
                    e = sb.pop_front();
                    check({tag, " idx"}, 64'(idx_o), 64'(e.idx));
                    check({tag, " phase"}, 64'(out_phase_o), 64'(e.ph));
                    if (e.idx < 64) obs_ph[e.idx] = out_phase_o;
                    accepts++;
                end else begin
                    check({tag, " held idx"}, 64'(idx_o), 64'(sb[0].idx));
                    check({tag, " held phase"}, 64'(out_phase_o), 64'(sb[0].ph));
                end
            end
            if (tail > 0) tail--;
            else if (tail < 0 && done_o) tail = 2;
            @(posedge clk_i); #1;
            abort_i = 1'b0;
            start_i = 1'b0;
            if (stall > 0) begin
                stall--;
                if (stall == 0) out_ready_i = 1'b1;
            end else if (!stalled && out_valid_o && int'(idx_o) == stall_idx) begin
                stalled     = 1;
                stall       = 4;
                out_ready_i = 1'b0;
            end
            if (!started && out_valid_o && int'(idx_o) == start_idx) begin
                started = 1;
                start_i = 1'b1;
            end
            if (!aborted && out_valid_o && out_ready_i && int'(idx_o) == abort_idx) begin
                aborted     = 1;
                abort_i     = 1'b1;
                since_abort = 0;
                tail        = 4;
            end
        end
        check({tag, " finished"}, 64'(tail == 0), 1);
        check({tag, " accepts"}, 64'(accepts), 64'((abort_idx >= 0) ? abort_idx : mlen));
        check({tag, " done pulses"}, 64'(dones), 64'((abort_idx >= 0) ? 0 : 1));
        out_ready_i = 1'b1;
        abort_i     = 1'b0;
        start_i     = 1'b0;
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("reset idx", 64'(idx_o), 0);
        check("reset phase", 64'(out_phase_o), 0);
        check("reset valid", 64'(out_valid_o), 0);
        check("reset busy", 64'(busy_o), 0);
        check("reset done", 64'(done_o), 0);

        // Long mode with wrap at Nzc, spot values fixed by hand.
        run_seq("zc36", 36, 1, 31, 3'b000, '0, -1, -1, -1);
        check("zc36 idx0", 64'(obs_ph[0][14:0]), 0);
        check("zc36 idx1", 64'(obs_ph[1][14:0]), 31711);
        check("zc36 idx2", 64'(obs_ph[2][14:0]), 29597);
        check("zc36 idx31", 64'(obs_ph[31][14:0]), 0);

        // Backpressure at idx 7 and a start pulse mid-run that must be ignored.
        run_seq("stall", 36, 1, 31, 3'b000, '0, 7, 10, -1);

        run_seq("short m3", 12, 0, 11, 3'b101, '0, -1, -1, -1);
        check("short m3 lit", 64'(obs_ph[4]), 64'({15'h5000, 15'h5000}));
        run_seq("short p1", 12, 0, 11, 3'b001, '0, -1, -1, -1);
        check("short p1 lit", 64'(obs_ph[0]), 64'({15'h1000, 15'h1000}));

        run_seq("zc48", 48, 7, 47, 3'b000, '0, -1, -1, -1);
        run_seq("m30", 30, 5, 31, 3'b000, '0, -1, -1, -1);
        run_seq("unsup", 20, 3, 19, 3'b011, '0, -1, -1, -1);
        run_seq("abort", 36, 2, 31, 3'b000, '0, -1, -1, 3);

`ifdef DMRS_CS_EN
        run_seq("cs", 12, 0, 11, 3'b001, {15'h4000, 15'h0000}, -1, -1, -1);
        check("cs p1 idx0", 64'(obs_ph[0][29:15]), 64'h1000);
        check("cs p1 idx1", 64'(obs_ph[1][29:15]), 64'h5000);
        check("cs p0 idx1", 64'(obs_ph[1][14:0]), 64'h1000);
`endif

        // Reset asserted mid-run at idx 5.
        m_len_i   = 10'd36;
        q_i       = 10'd1;
        nzc_i     = 10'd31;
        nzc_rec_i = 30'(rec_of(31));
        @(posedge clk_i); #1 start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
        for (int c = 0; c < 50 && !(out_valid_o && idx_o == 10'd5); c++) @(negedge clk_i);
        check("rst reach idx5", 64'(out_valid_o && idx_o == 10'd5), 1);
        #1 rst_ni = 1'b0;
        #1;
        check("rst idx", 64'(idx_o), 0);
        check("rst phase", 64'(out_phase_o), 0);
        check("rst valid", 64'(out_valid_o), 0);
        check("rst busy", 64'(busy_o), 0);
        check("rst done", 64'(done_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_seq("after rst", 36, 1, 31, 3'b000, '0, -1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
